coo_pair_gen: RTL

COO_PAIR_GEN -- requirements
Module: coo_pair_gen

---
 rtl/coo_pair_gen_if.sv | 38 +++
 rtl/coo_pair_gen.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/coo_pair_gen_if.sv
// rtl/coo_pair_gen_if.sv - COO entry input and product-pair output bundle
interface coo_pair_gen_if #(
    parameter int DATA_SIZE = 16,
    parameter int M         = 4,
    parameter int N         = 4,
    parameter int K         = 4
);
    localparam int MN = (M > N) ? M : N;
    localparam int NK = (N > K) ? N : K;
    localparam int RW = ($clog2(MN) > 1) ? $clog2(MN) : 1;
    localparam int CW = ($clog2(NK) > 1) ? $clog2(NK) : 1;

    logic                 in_valid;
    logic                 in_ready;
    logic                 in_sel;
    logic [RW-1:0]        in_row;
    logic [CW-1:0]        in_col;
    logic [DATA_SIZE-1:0] in_val;
    logic                 in_last;
    logic                 out_valid;
    logic                 out_ready;
    logic [DATA_SIZE-1:0] out_a_val;
    logic [DATA_SIZE-1:0] out_b_val;
    logic [RW-1:0]        out_row;
    logic [CW-1:0]        out_col;
    logic                 done;
    logic                 overflow;

    modport master (
        output in_valid, in_sel, in_row, in_col, in_val, in_last, out_ready,
        input  in_ready, out_valid, out_a_val, out_b_val, out_row, out_col, done, overflow
    );

    modport slave (
        input  in_valid, in_sel, in_row, in_col, in_val, in_last, out_ready,
        output in_ready, out_valid, out_a_val, out_b_val, out_row, out_col, done, overflow
    );
endinterface

// File: rtl/coo_pair_gen.sv
// rtl/coo_pair_gen.sv - loads sparse A and B COO lists, then emits every (A,B) pair whose
// A column equals the B row, in A-major order, for a downstream MAC array.
module coo_pair_gen #(
    parameter int DATA_SIZE     = 16,
    parameter int M             = 4,
    parameter int N             = 4,
    parameter int K             = 4,
    parameter int MAX_LIST_SIZE = 30
) (
    input  logic          clk,
    input  logic          rst_n,
    coo_pair_gen_if.slave bus
);
    localparam int MN   = (M > N) ? M : N;
    localparam int NK   = (N > K) ? N : K;
    localparam int RW   = ($clog2(MN) > 1) ? $clog2(MN) : 1;
    localparam int CW   = ($clog2(NK) > 1) ? $clog2(NK) : 1;
    localparam int CNTW = $clog2(MAX_LIST_SIZE + 1);
    localparam int IDXW = (MAX_LIST_SIZE > 1) ? $clog2(MAX_LIST_SIZE) : 1;

    typedef enum logic [1:0] {LOAD, SCAN, DONE} state_t;

    state_t          state_q, state_d;
    logic [CNTW-1:0] a_cnt_q, a_cnt_d, b_cnt_q, b_cnt_d;
    logic            a_last_q, a_last_d, b_last_q, b_last_d;
    logic            overflow_q, overflow_d;
    logic            en_q, en_d;
    logic [IDXW-1:0] ai_q, ai_d, bi_q, bi_d;

    logic [RW-1:0]        a_row_mem [MAX_LIST_SIZE];
    logic [CW-1:0]        a_col_mem [MAX_LIST_SIZE];
    logic [DATA_SIZE-1:0] a_val_mem [MAX_LIST_SIZE];
    logic [RW-1:0]        b_row_mem [MAX_LIST_SIZE];
    logic [CW-1:0]        b_col_mem [MAX_LIST_SIZE];
    logic [DATA_SIZE-1:0] b_val_mem [MAX_LIST_SIZE];

    logic accept, a_drop, b_drop, a_we, b_we, nonempty, match, bi_end, ai_end;

    // en_q keeps in_ready low while reset is held and for no longer than the first clock edge after
    assign bus.in_ready  = (state_q == LOAD) && en_q;
    assign bus.out_valid = (state_q == SCAN) && nonempty && match;
    assign bus.out_a_val = a_val_mem[ai_q];
    assign bus.out_b_val = b_val_mem[bi_q];
    assign bus.out_row   = a_row_mem[ai_q];
    assign bus.out_col   = b_col_mem[bi_q];
    assign bus.done      = (state_q == DONE);
    assign bus.overflow  = overflow_q;

    always_comb begin
        state_d    = state_q;
        a_cnt_d    = a_cnt_q;
        b_cnt_d    = b_cnt_q;
        a_last_d   = a_last_q;
        b_last_d   = b_last_q;
        overflow_d = overflow_q;
        en_d       = 1'b1;
        ai_d       = ai_q;
        bi_d       = bi_q;

        accept   = bus.in_valid && bus.in_ready;
        a_drop   = (32'(a_cnt_q) == MAX_LIST_SIZE) || a_last_q ||
                   (32'(bus.in_row) >= M) || (32'(bus.in_col) >= N);
        b_drop   = (32'(b_cnt_q) == MAX_LIST_SIZE) || b_last_q ||
                   (32'(bus.in_row) >= N) || (32'(bus.in_col) >= K);
        a_we     = accept && !bus.in_sel && !a_drop;
        b_we     = accept &&  bus.in_sel && !b_drop;
        nonempty = (a_cnt_q != '0) && (b_cnt_q != '0);
        match    = (32'(a_col_mem[ai_q]) == 32'(b_row_mem[bi_q]));
        bi_end   = (32'(bi_q) + 32'd1 == 32'(b_cnt_q));
        ai_end   = (32'(ai_q) + 32'd1 == 32'(a_cnt_q));

        case (state_q)
            LOAD: begin
                if (accept) begin
                    if (!bus.in_sel) begin
                        if (a_drop) overflow_d = 1'b1;
                        else        a_cnt_d    = a_cnt_q + CNTW'(1);
                        if (bus.in_last) a_last_d = 1'b1;
                    end else begin
                        if (b_drop) overflow_d = 1'b1;
                        else        b_cnt_d    = b_cnt_q + CNTW'(1);
                        if (bus.in_last) b_last_d = 1'b1;
                    end
                end
                if (a_last_d && b_last_d) begin
                    state_d = SCAN;
                    ai_d    = '0;
                    bi_d    = '0;
                end
            end
            SCAN: begin
                if (!nonempty) begin
                    state_d = DONE;
                end else if (!match || bus.out_ready) begin
                    // a presented pair holds the counters until the MAC array takes it
                    if (bi_end) begin
                        bi_d = '0;
                        if (ai_end) state_d = DONE;
                        else        ai_d    = ai_q + IDXW'(1);
                    end else begin
                        bi_d = bi_q + IDXW'(1);
                    end
                end
            end
            DONE: begin
                state_d  = LOAD;
                a_cnt_d  = '0;
                b_cnt_d  = '0;
                a_last_d = 1'b0;
                b_last_d = 1'b0;
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= LOAD;
            a_cnt_q    <= '0;
            b_cnt_q    <= '0;
            a_last_q   <= 1'b0;
            b_last_q   <= 1'b0;
            overflow_q <= 1'b0;
            en_q       <= 1'b0;
            ai_q       <= '0;
            bi_q       <= '0;
        end else begin
            state_q    <= state_d;
            a_cnt_q    <= a_cnt_d;
            b_cnt_q    <= b_cnt_d;
            a_last_q   <= a_last_d;
            b_last_q   <= b_last_d;
            overflow_q <= overflow_d;
            en_q       <= en_d;
            ai_q       <= ai_d;
            bi_q       <= bi_d;
        end
    end

    always_ff @(posedge clk) begin
        if (a_we) begin
            a_row_mem[a_cnt_q[IDXW-1:0]] <= bus.in_row;
            a_col_mem[a_cnt_q[IDXW-1:0]] <= bus.in_col;
            a_val_mem[a_cnt_q[IDXW-1:0]] <= bus.in_val;
        end
        if (b_we) begin
            b_row_mem[b_cnt_q[IDXW-1:0]] <= bus.in_row;
            b_col_mem[b_cnt_q[IDXW-1:0]] <= bus.in_col;
            b_val_mem[b_cnt_q[IDXW-1:0]] <= bus.in_val;
        end
    end
endmodule
